// File: rtl/lcd_timing_gen.sv
// Raster timing and test-pattern generator for the 800x480 parallel RGB panel.
// Free-running h/v counters are decoded and re-registered so that all panel outputs share one cycle of latency.
module lcd_timing_gen #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 210,
  parameter int   H_SYNC   = 20,
  parameter int   H_BP     = 26,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 22,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   BAR_W    = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [10:0] HS_FIRST  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_FIRST  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_BLACK = 2'd3
  } pat_e;

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  pat_e        pat_q, pat_eff;

  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic [15:0] rgb_q, rgb_d;
  logic [10:0] px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic        fs_q, fs_d;

  logic        de_c, hs_c, vs_c, origin_c;
  logic [10:0] bar_div;
  logic [2:0]  bar_idx;
  logic [15:0] rgb_c;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end else begin
      h_cnt_d = h_cnt_q + 11'd1;
    end
  end

  assign de_c     = (h_cnt_q < 11'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
  assign hs_c     = ((h_cnt_q >= HS_FIRST) && (h_cnt_q < HS_END)) ^ ~HS_POL;
  assign vs_c     = ((v_cnt_q >= VS_FIRST) && (v_cnt_q < VS_END)) ^ ~VS_POL;
  assign origin_c = (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);

  // The pattern captured at the origin already applies to pixel (0,0) itself.
  assign pat_eff  = origin_c ? pat_e'(pattern_sel) : pat_q;

  assign bar_div  = h_cnt_q / 11'(BAR_W);
  assign bar_idx  = (bar_div > 11'd7) ? 3'd7 : bar_div[2:0];

  always_comb begin
    rgb_c = 16'h0000;
    if (de_c) begin
      case (pat_eff)
        PAT_BARS: begin
          case (bar_idx)
            3'd0:    rgb_c = 16'hFFFF;
            3'd1:    rgb_c = 16'hFFE0;
            3'd2:    rgb_c = 16'h07FF;
            3'd3:    rgb_c = 16'h07E0;
            3'd4:    rgb_c = 16'hF81F;
            3'd5:    rgb_c = 16'hF800;
            3'd6:    rgb_c = 16'h001F;
            default: rgb_c = 16'h0000;
          endcase
        end
        PAT_GRID: begin
          if ((h_cnt_q[4:0] == 5'd0) || (v_cnt_q[4:0] == 5'd0) ||
              (h_cnt_q == 11'(H_ACTIVE - 1)) || (v_cnt_q == 10'(V_ACTIVE - 1)))
            rgb_c = 16'hFFFF;
        end
        PAT_SOLID: rgb_c = solid_rgb;
        default:   rgb_c = 16'h0000;
      endcase
    end
  end

  // With en low every output is forced idle on the same edge that zeroes the counters.
  always_comb begin
    hs_d = ~HS_POL;
    vs_d = ~VS_POL;
    de_d = 1'b0;
    rgb_d = 16'h0000;
    px_d = 11'd0;
    py_d = 10'd0;
    fs_d = 1'b0;
    if (en) begin
      hs_d  = hs_c;
      vs_d  = vs_c;
      de_d  = de_c;
      rgb_d = rgb_c;
      px_d  = de_c ? h_cnt_q : px_q;
      py_d  = de_c ? v_cnt_q : py_q;
      fs_d  = origin_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      pat_q   <= PAT_BARS;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      rgb_q   <= 16'h0000;
      px_q    <= 11'd0;
      py_q    <= 10'd0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      pat_q   <= pat_eff;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      px_q    <= px_d;
      py_q    <= py_d;
      fs_q    <= fs_d;
    end
  end

  assign lcd_hs      = hs_q;
  assign lcd_vs      = vs_q;
  assign lcd_de      = de_q;
  assign lcd_rgb     = rgb_q;
  assign pixel_x     = px_q;
  assign pixel_y     = py_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: cycle model feeding a scoreboard queue plus directed timing checks.
// Vertical timing is shortened so several frames fit in a short run; horizontal timing is the real panel's.
module tb_lcd_timing_gen;

  localparam int HA = 800, HF = 210, HSW = 20, HB = 26;
  localparam int VA = 10,  VF = 2,   VSW = 2,  VB = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] rgb;
    logic [10:0] px;
    logic [9:0]  py;
    logic        fs;
  } out_t;

  localparam out_t RST_OUT = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 16'h0, px: 11'd0, py: 10'd0, fs: 1'b0};
  localparam logic [15:0] BAR_COL [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb;
  logic        lcd_hs, lcd_vs, lcd_de, frame_start;
  logic [15:0] lcd_rgb;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  out_t sb[$];

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .BAR_W(100)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #15 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: predicts what the panel pins should show after each edge.
  initial begin
    int mh, mv, idx;
    logic [1:0]  mpat;
    logic [10:0] mpx;
    logic [9:0]  mpy;
    out_t e;
    mh = 0; mv = 0; mpat = 2'd0; mpx = '0; mpy = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mh = 0; mv = 0; mpat = 2'd0; mpx = '0; mpy = '0;
        sb.delete();
        sb.push_back(RST_OUT);
      end else begin
        e = RST_OUT;
        if (mh == 0 && mv == 0) mpat = pattern_sel;
        if (en) begin
          e.de = (mh < HA) && (mv < VA);
          e.hs = !((mh >= HA + HF) && (mh < HA + HF + HSW));
          e.vs = !((mv >= VA + VF) && (mv < VA + VF + VSW));
          if (e.de) begin
            idx = mh / 100;
            if (idx > 7) idx = 7;
            case (mpat)
              2'd0: e.rgb = BAR_COL[idx];
              2'd1: e.rgb = ((mh % 32 == 0) || (mv % 32 == 0) || (mh == HA - 1) || (mv == VA - 1)) ? 16'hFFFF : 16'h0000;
              2'd2: e.rgb = solid_rgb;
              default: e.rgb = 16'h0000;
            endcase
            mpx = 11'(mh);
            mpy = 10'(mv);
          end
          e.px = mpx;
          e.py = mpy;
          e.fs = (mh == 0) && (mv == 0);
          mh++;
          if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
          end
        end else begin
          mh = 0; mv = 0; mpx = '0; mpy = '0;
        end
        sb.push_back(e);
      end
    end
  end

  initial forever begin
    out_t got, exp_o;
    @(negedge clk);
    if (sb.size() > 0) begin
      exp_o = sb.pop_front();
      got   = '{hs: lcd_hs, vs: lcd_vs, de: lcd_de, rgb: lcd_rgb, px: pixel_x, py: pixel_y, fs: frame_start};
      check("scoreboard", 64'(got), 64'(exp_o));
    end
  end

  task automatic waitPixel(input int x, input int y);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(lcd_de && (pixel_x == 11'(x)) && (pixel_y == 10'(y))) && n < 40000);
    check($sformatf("reach_%0d_%0d", x, y), 64'(n < 40000), 64'(1));
  endtask

  initial begin
    int n, t0, t1;
    rst = 1'b0; en = 1'b1; pattern_sel = 2'd0; solid_rgb = 16'h1234;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({lcd_hs, lcd_vs, lcd_de, lcd_rgb, pixel_x, pixel_y, frame_start}),
          64'({1'b1, 1'b1, 1'b0, 16'h0000, 11'd0, 10'd0, 1'b0}));

    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("no_de_at_release", 64'(lcd_de), 64'(0));
    @(negedge clk);
    check("first_pixel", 64'({lcd_de, frame_start, lcd_rgb, pixel_x, pixel_y}),
          64'({1'b1, 1'b1, 16'hFFFF, 11'd0, 10'd0}));
    t0 = cyc;

    n = 0;
    while (lcd_de && n < 2000) begin
      if (pixel_x == 11'd100) check("bar_x100", 64'(lcd_rgb), 64'(16'hFFE0));
      if (pixel_x == 11'd799) check("bar_x799", 64'(lcd_rgb), 64'(16'h0000));
      n++;
      @(negedge clk);
    end
    check("de_run_length", 64'(n), 64'(800));

    while (lcd_hs && cyc - t0 < 2000) @(negedge clk);
    check("hs_start", 64'(cyc - t0), 64'(1010));
    n = 0;
    while (!lcd_hs && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("hs_width", 64'(n), 64'(20));
    while (!lcd_de && cyc - t0 < 3000) @(negedge clk);
    check("line_period", 64'(cyc - t0), 64'(HT));

    pattern_sel = 2'd1;
    waitPixel(100, 5);
    check("bars_persist", 64'(lcd_rgb), 64'(16'hFFE0));

    while (lcd_vs && cyc - t0 < 20000) @(negedge clk);
    check("vs_start", 64'(cyc - t0), 64'((VA + VF) * HT));
    check("last_de_line", 64'(pixel_y), 64'(VA - 1));
    t1 = cyc;
    while (!lcd_vs && cyc - t1 < 5000) @(negedge clk);
    check("vs_width", 64'(cyc - t1), 64'(VSW * HT));

    while (!frame_start && cyc - t0 < 20000) @(negedge clk);
    check("frame_period", 64'(cyc - t0), 64'(VT * HT));
    check("grid_origin", 64'(lcd_rgb), 64'(16'hFFFF));
    waitPixel(1, 1);
    check("grid_1_1", 64'(lcd_rgb), 64'(16'h0000));
    waitPixel(32, 5);
    check("grid_32_5", 64'(lcd_rgb), 64'(16'hFFFF));
    waitPixel(799, 5);
    check("grid_799_5", 64'(lcd_rgb), 64'(16'hFFFF));

    waitPixel(400, 6);
    pattern_sel = 2'd2;
    en = 1'b0;
    @(negedge clk);
    check("en_low_idle", 64'({lcd_hs, lcd_vs, lcd_de, frame_start, lcd_rgb}),
          64'({1'b1, 1'b1, 1'b0, 1'b0, 16'h0000}));
    repeat (49) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("en_restart", 64'({lcd_de, frame_start, pixel_x, pixel_y, lcd_rgb}),
          64'({1'b1, 1'b1, 11'd0, 10'd0, 16'h1234}));
    solid_rgb = 16'hABCD;
    @(negedge clk);
    check("solid_resample", 64'(lcd_rgb), 64'(16'hABCD));

    pattern_sel = 2'd3;
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("black_origin", 64'({lcd_de, frame_start, lcd_rgb}), 64'({1'b1, 1'b1, 16'h0000}));

    waitPixel(200, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #2;
    check("async_reset", 64'({lcd_hs, lcd_vs, lcd_de, lcd_rgb, pixel_x, pixel_y, frame_start}),
          64'({1'b1, 1'b1, 1'b0, 16'h0000, 11'd0, 10'd0, 1'b0}));
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("restart_after_reset", 64'({lcd_de, frame_start, pixel_x, pixel_y}),
          64'({1'b1, 1'b1, 11'd0, 10'd0}));
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
